reorder_buffer: RTL and testbench

Circular reorder buffer for the out-of-order core. It allocates one ROB tag per dispatched instruction, records completion and results broadcast on the CDB, and retires in program order from the head. It is the producer of `rob_tail_packet`, `rob_head_packet`, `retire_valid` and the tag space that the map table and reservation stations consume. It also serves two operand-value read ports for RS operands whose map entry has `t_plus` set.

---
 rtl/reorder_buffer_pkg.sv | 41 ++++
 rtl/reorder_buffer_if.sv | 33 +++
 rtl/reorder_buffer_rob_ptr.sv | 22 ++
 rtl/reorder_buffer.sv | 125 ++++++++++++
 tb/tb_reorder_buffer.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the reorder buffer slice.
// Tags run 1..ROB_SZ; tag 0 means "no tag".
package reorder_buffer_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned ROB_SZ      = 8;
    localparam int unsigned ROB_TAG_LEN = $clog2(ROB_SZ + 1);
    localparam int unsigned ROB_IDX_LEN = $clog2(ROB_SZ);
    localparam int unsigned CNT_LEN     = $clog2(ROB_SZ + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [4:0]      dest_reg_idx;
    } id_ex_packet_t;

    typedef struct packed {
        logic [ROB_TAG_LEN-1:0] rob_tag;
        logic [XLEN-1:0]        value;
    } cdb_packet_t;

    typedef struct packed {
        id_ex_packet_t          id_packet;
        logic [ROB_TAG_LEN-1:0] rob_tag;
        logic [XLEN-1:0]        value;
        logic                   complete;
    } rob_entry_t;

    function automatic logic [ROB_TAG_LEN-1:0] idx_to_tag(input logic [ROB_IDX_LEN-1:0] idx);
        return ROB_TAG_LEN'(idx) + ROB_TAG_LEN'(1);
    endfunction

    function automatic logic [ROB_IDX_LEN-1:0] tag_to_idx(input logic [ROB_TAG_LEN-1:0] tag);
        return ROB_IDX_LEN'(tag - ROB_TAG_LEN'(1));
    endfunction

    function automatic logic tag_in_range(input logic [ROB_TAG_LEN-1:0] tag);
        return (tag != '0) && (tag <= ROB_TAG_LEN'(ROB_SZ));
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, CDB, operand-read and retire signals between the core and the ROB.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    id_ex_packet_t          id_packet;
    logic                   dispatch_valid;
    logic                   squash;
    cdb_packet_t            cdb_packet;
    logic [ROB_TAG_LEN-1:0] read_tag_a;
    logic [ROB_TAG_LEN-1:0] read_tag_b;
    logic [XLEN-1:0]        read_value_a;
    logic [XLEN-1:0]        read_value_b;
    logic                   read_ready_a;
    logic                   read_ready_b;
    rob_entry_t             rob_tail_packet;
    rob_entry_t             rob_head_packet;
    logic                   retire_valid;
    logic                   rob_full;
    logic                   rob_empty;

    modport master (
        output id_packet, dispatch_valid, squash, cdb_packet, read_tag_a, read_tag_b,
        input  read_value_a, read_value_b, read_ready_a, read_ready_b,
               rob_tail_packet, rob_head_packet, retire_valid, rob_full, rob_empty
    );

    modport slave (
        input  id_packet, dispatch_valid, squash, cdb_packet, read_tag_a, read_tag_b,
        output read_value_a, read_value_b, read_ready_a, read_ready_b,
               rob_tail_packet, rob_head_packet, retire_valid, rob_full, rob_empty
    );

endinterface

// File: rtl/reorder_buffer_rob_ptr.sv
// Wrapping 0..ROB_SZ-1 pointer with increment and synchronous clear.
module rob_ptr
    import reorder_buffer_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   inc,
    output logic [ROB_IDX_LEN-1:0] ptr
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == ROB_IDX_LEN'(ROB_SZ - 1)) ? '0 : ptr + ROB_IDX_LEN'(1);
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at dispatch, records CDB completions,
// retires in order from the head and serves two operand read ports.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    reorder_buffer_if.slave  bus
);

    logic [ROB_SZ-1:0]      valid;
    logic [ROB_SZ-1:0]      complete;
    id_ex_packet_t          ids    [ROB_SZ];
    logic [XLEN-1:0]        values [ROB_SZ];
    logic [CNT_LEN-1:0]     count;
    logic [ROB_IDX_LEN-1:0] head;
    logic [ROB_IDX_LEN-1:0] tail;
    logic [ROB_IDX_LEN-1:0] cdb_idx;
    logic                   dispatch_ok;
    logic                   retire;
    logic                   cdb_hit;
    logic                   full;
    logic                   empty;

    assign full        = (count == CNT_LEN'(ROB_SZ));
    assign empty       = (count == '0);
    assign dispatch_ok = bus.dispatch_valid && !full && !bus.squash;
    assign retire      = !empty && complete[head] && !bus.squash;
    assign cdb_idx     = tag_to_idx(bus.cdb_packet.rob_tag);
    assign cdb_hit     = tag_in_range(bus.cdb_packet.rob_tag) && valid[cdb_idx] && !bus.squash;

    rob_ptr u_head (.clock(clock), .reset(reset), .clear(bus.squash), .inc(retire),      .ptr(head));
    rob_ptr u_tail (.clock(clock), .reset(reset), .clear(bus.squash), .inc(dispatch_ok), .ptr(tail));

    // Write order gives dispatch the last word over a stray CDB hit on the same slot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid    <= '0;
            complete <= '0;
            for (int unsigned i = 0; i < ROB_SZ; i++) begin
                ids[i]    <= '0;
                values[i] <= '0;
            end
        end else if (bus.squash) begin
            valid    <= '0;
            complete <= '0;
        end else begin
            for (int unsigned i = 0; i < ROB_SZ; i++) begin
                if (cdb_hit && cdb_idx == ROB_IDX_LEN'(i)) begin
                    complete[i] <= 1'b1;
                    values[i]   <= bus.cdb_packet.value;
                end
                if (retire && head == ROB_IDX_LEN'(i)) begin
                    valid[i]    <= 1'b0;
                    complete[i] <= 1'b0;
                end
                if (dispatch_ok && tail == ROB_IDX_LEN'(i)) begin
                    valid[i]    <= 1'b1;
                    complete[i] <= 1'b0;
                    ids[i]      <= bus.id_packet;
                    values[i]   <= '0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (bus.squash) begin
            count <= '0;
        end else begin
            case ({dispatch_ok, retire})
                2'b10:   count <= count + CNT_LEN'(1);
                2'b01:   count <= count - CNT_LEN'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.rob_full     = full;
    assign bus.rob_empty    = empty;
    assign bus.retire_valid = retire;

    always_comb begin
        bus.rob_head_packet = '0;
        if (!empty) begin
            bus.rob_head_packet.id_packet = ids[head];
            bus.rob_head_packet.rob_tag   = idx_to_tag(head);
            bus.rob_head_packet.value     = values[head];
            bus.rob_head_packet.complete  = complete[head];
        end
        bus.rob_tail_packet           = '0;
        bus.rob_tail_packet.id_packet = bus.id_packet;
        bus.rob_tail_packet.rob_tag   = idx_to_tag(tail);
    end

    // Operand read ports; a live CDB broadcast of the same tag bypasses storage.
    logic [ROB_TAG_LEN-1:0] rd_tag   [2];
    logic [XLEN-1:0]        rd_value [2];
    logic                   rd_ready [2];

    assign rd_tag[0] = bus.read_tag_a;
    assign rd_tag[1] = bus.read_tag_b;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_value[p] = '0;
            rd_ready[p] = 1'b0;
            if (rd_tag[p] != '0 && bus.cdb_packet.rob_tag == rd_tag[p]) begin
                rd_value[p] = bus.cdb_packet.value;
                rd_ready[p] = 1'b1;
            end else if (tag_in_range(rd_tag[p]) && valid[tag_to_idx(rd_tag[p])]) begin
                rd_value[p] = values[tag_to_idx(rd_tag[p])];
                rd_ready[p] = complete[tag_to_idx(rd_tag[p])];
            end
        end
    end

    assign bus.read_value_a = rd_value[0];
    assign bus.read_ready_a = rd_ready[0];
    assign bus.read_value_b = rd_value[1];
    assign bus.read_ready_b = rd_ready[1];

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a vector table for the CDB/retire/bypass
// flow plus hand-written sequences for reset, full/wrap, count-7 and squash.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clock;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    logic [XLEN-1:0] pc_drv = 32'hC0DE_0000;

    reorder_buffer_if bus ();

    reorder_buffer dut (.clock(clock), .reset(reset), .bus(bus));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] dv, sq, ctag, cval, ra, rb;
        logic [31:0] e_empty, e_full, e_rv, e_tail, e_head, e_hval;
        logic [31:0] e_rdy_a, e_val_a, e_rdy_b, e_val_b;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; outputs settle 1 ns later.
    task automatic step(input int dv, input int sq, input int ctag, input int cval,
                        input int ra, input int rb);
        @(negedge clock);
        pc_drv = pc_drv + 32'd4;
        bus.id_packet.pc           = pc_drv;
        bus.id_packet.inst         = 32'h0000_0013;
        bus.id_packet.dest_reg_idx = 5'd1;
        bus.dispatch_valid         = 1'(dv);
        bus.squash                 = 1'(sq);
        bus.cdb_packet.rob_tag     = ROB_TAG_LEN'(ctag);
        bus.cdb_packet.value       = XLEN'(cval);
        bus.read_tag_a             = ROB_TAG_LEN'(ra);
        bus.read_tag_b             = ROB_TAG_LEN'(rb);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        bus.dispatch_valid     = 1'b0;
        bus.squash             = 1'b0;
        bus.cdb_packet.rob_tag = '0;
        bus.read_tag_a         = '0;
        bus.read_tag_b         = '0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        //          dv sq ctag cval    ra rb | emp full rv tail head hval    rdya vala    rdyb valb
        vecs[0]  = '{0, 0, 0, 0,       0, 0,   1,  0,  0,  1,   0,  0,       0,  0,      0,  0};
        vecs[1]  = '{1, 0, 0, 0,       0, 0,   1,  0,  0,  1,   0,  0,       0,  0,      0,  0};
        vecs[2]  = '{1, 0, 0, 0,       0, 0,   0,  0,  0,  2,   1,  0,       0,  0,      0,  0};
        vecs[3]  = '{0, 0, 2, 'h55,    2, 1,   0,  0,  0,  3,   1,  0,       1,  'h55,   0,  0};
        vecs[4]  = '{0, 0, 1, 'hAA,    2, 1,   0,  0,  0,  3,   1,  0,       1,  'h55,   1,  'hAA};
        vecs[5]  = '{0, 0, 0, 0,       2, 1,   0,  0,  1,  3,   1,  'hAA,    1,  'h55,   1,  'hAA};
        vecs[6]  = '{0, 0, 0, 0,       2, 1,   0,  0,  1,  3,   2,  'h55,    1,  'h55,   0,  0};
        vecs[7]  = '{0, 0, 0, 0,       2, 0,   1,  0,  0,  3,   0,  0,       0,  0,      0,  0};
        vecs[8]  = '{1, 0, 0, 0,       3, 0,   1,  0,  0,  3,   0,  0,       0,  0,      0,  0};
        vecs[9]  = '{0, 0, 3, 'h1234,  3, 0,   0,  0,  0,  4,   3,  0,       1,  'h1234, 0,  0};
        vecs[10] = '{0, 0, 0, 0,       3, 0,   0,  0,  1,  4,   3,  'h1234,  1,  'h1234, 0,  0};
        vecs[11] = '{0, 0, 0, 0,       3, 0,   1,  0,  0,  4,   0,  0,       0,  0,      0,  0};

        reset = 1'b0;
        bus.id_packet      = '0;
        bus.dispatch_valid = 1'b0;
        bus.squash         = 1'b0;
        bus.cdb_packet     = '0;
        bus.read_tag_a     = '0;
        bus.read_tag_b     = '0;
        #12;
        chk("rst_empty",    32'(bus.rob_empty), 1);
        chk("rst_full",     32'(bus.rob_full), 0);
        chk("rst_retire",   32'(bus.retire_valid), 0);
        chk("rst_tail_tag", 32'(bus.rob_tail_packet.rob_tag), 1);
        chk("rst_head",     32'(bus.rob_head_packet.rob_tag), 0);
        @(negedge clock);
        reset = 1'b1;

        // Table: out-of-order CDB, in-order retire, bypass then storage read.
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].dv, vecs[i].sq, vecs[i].ctag, vecs[i].cval, vecs[i].ra, vecs[i].rb);
            chk($sformatf("v%0d_empty", i), 32'(bus.rob_empty), vecs[i].e_empty);
            chk($sformatf("v%0d_full", i),  32'(bus.rob_full), vecs[i].e_full);
            chk($sformatf("v%0d_retire", i), 32'(bus.retire_valid), vecs[i].e_rv);
            chk($sformatf("v%0d_tail_tag", i), 32'(bus.rob_tail_packet.rob_tag), vecs[i].e_tail);
            chk($sformatf("v%0d_head_tag", i), 32'(bus.rob_head_packet.rob_tag), vecs[i].e_head);
            chk($sformatf("v%0d_head_val", i), 32'(bus.rob_head_packet.value), vecs[i].e_hval);
            chk($sformatf("v%0d_rdy_a", i), 32'(bus.read_ready_a), vecs[i].e_rdy_a);
            chk($sformatf("v%0d_val_a", i), 32'(bus.read_value_a), vecs[i].e_val_a);
            chk($sformatf("v%0d_rdy_b", i), 32'(bus.read_ready_b), vecs[i].e_rdy_b);
            chk($sformatf("v%0d_val_b", i), 32'(bus.read_value_b), vecs[i].e_val_b);
        end

        // Mid-run asynchronous reset with three entries live.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
        idle();
        chk("mid_pre_empty", 32'(bus.rob_empty), 0);
        chk("mid_pre_tail",  32'(bus.rob_tail_packet.rob_tag), 7);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_empty",  32'(bus.rob_empty), 1);
        chk("mid_rst_full",   32'(bus.rob_full), 0);
        chk("mid_rst_retire", 32'(bus.retire_valid), 0);
        chk("mid_rst_tail",   32'(bus.rob_tail_packet.rob_tag), 1);
        chk("mid_rst_head",   32'(bus.rob_head_packet), 0);
        @(negedge clock);
        reset = 1'b1;

        // Fill to eight, drop a ninth, retire one, wrap to tag 1.
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 0, 0, 0);
            chk($sformatf("fill%0d_tail", i), 32'(bus.rob_tail_packet.rob_tag), 32'(i + 1));
            chk($sformatf("fill%0d_full", i), 32'(bus.rob_full), 0);
        end
        step(1, 0, 0, 0, 0, 0);
        chk("ninth_full", 32'(bus.rob_full), 1);
        chk("ninth_tail", 32'(bus.rob_tail_packet.rob_tag), 1);
        step(0, 0, 1, 'h77, 0, 0);
        chk("after9_full", 32'(bus.rob_full), 1);
        chk("after9_tail", 32'(bus.rob_tail_packet.rob_tag), 1);
        idle();
        chk("full_retire",    32'(bus.retire_valid), 1);
        chk("full_head_tag",  32'(bus.rob_head_packet.rob_tag), 1);
        chk("full_head_val",  32'(bus.rob_head_packet.value), 'h77);
        step(1, 0, 0, 0, 0, 0);
        chk("wrap_full",      32'(bus.rob_full), 0);
        chk("wrap_tail_tag",  32'(bus.rob_tail_packet.rob_tag), 1);
        chk("wrap_tail_cmpl", 32'(bus.rob_tail_packet.complete), 0);
        chk("wrap_tail_pc",   32'(bus.rob_tail_packet.id_packet.pc), pc_drv);
        chk("wrap_retire",    32'(bus.retire_valid), 0);
        idle();
        chk("wrap_refull",    32'(bus.rob_full), 1);
        chk("wrap_next_tail", 32'(bus.rob_tail_packet.rob_tag), 2);
        chk("wrap_head_tag",  32'(bus.rob_head_packet.rob_tag), 2);

        // Count 7: retire and dispatch in the same cycle.
        do_reset();
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 'h11, 0, 0);
        chk("c7_full_pre", 32'(bus.rob_full), 0);
        step(1, 0, 0, 0, 0, 0);
        chk("c7_retire",   32'(bus.retire_valid), 1);
        chk("c7_full",     32'(bus.rob_full), 0);
        chk("c7_tail",     32'(bus.rob_tail_packet.rob_tag), 8);
        idle();
        chk("c7_post_full", 32'(bus.rob_full), 0);
        chk("c7_post_tail", 32'(bus.rob_tail_packet.rob_tag), 1);
        chk("c7_post_head", 32'(bus.rob_head_packet.rob_tag), 2);
        chk("c7_post_rv",   32'(bus.retire_valid), 0);
        step(1, 0, 0, 0, 0, 0);
        idle();
        chk("c7_then_full", 32'(bus.rob_full), 1);

        // Squash over five entries with a complete head.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 'h22, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        chk("sq_retire",   32'(bus.retire_valid), 0);
        chk("sq_head_tag", 32'(bus.rob_head_packet.rob_tag), 1);
        idle();
        chk("sq_empty",    32'(bus.rob_empty), 1);
        chk("sq_tail",     32'(bus.rob_tail_packet.rob_tag), 1);
        chk("sq_head",     32'(bus.rob_head_packet), 0);
        step(0, 0, 4, 'h9, 0, 0);
        chk("sq_cdb_rv",   32'(bus.retire_valid), 0);
        step(0, 0, 0, 0, 4, 0);
        chk("sq_rd_rdy",   32'(bus.read_ready_a), 0);
        chk("sq_rd_val",   32'(bus.read_value_a), 0);
        chk("sq_empty2",   32'(bus.rob_empty), 1);
        chk("sq_rv2",      32'(bus.retire_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
